// File: rtl/nco_clkgen.sv
// Multi-channel NCO clock generator: per-channel phase accumulator with duty compare,
// and a one-deep pending config slot that is applied on wrap, while disabled, or on sync.
module nco_clkgen #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_ch_i,
  input  logic [WIDTH-1:0]    cfg_step_i,
  input  logic [WIDTH-1:0]    cfg_duty_i,
  input  logic                cfg_en_i,
  input  logic                sync_in_i,
  output logic [CHANNELS-1:0] clk_out_o,
  output logic [CHANNELS-1:0] tick_o
);

  localparam logic [WIDTH-1:0] DUTY_RST = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]    acc_q    [CHANNELS];
  logic [WIDTH-1:0]    acc_d    [CHANNELS];
  logic [WIDTH-1:0]    step_q   [CHANNELS];
  logic [WIDTH-1:0]    step_d   [CHANNELS];
  logic [WIDTH-1:0]    duty_q   [CHANNELS];
  logic [WIDTH-1:0]    duty_d   [CHANNELS];
  logic [WIDTH-1:0]    pstep_q  [CHANNELS];
  logic [WIDTH-1:0]    pstep_d  [CHANNELS];
  logic [WIDTH-1:0]    pduty_q  [CHANNELS];
  logic [WIDTH-1:0]    pduty_d  [CHANNELS];
  logic [WIDTH:0]      sum      [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d, pen_q, pen_d, pv_q, pv_d;
  logic [CHANNELS-1:0] clk_q, clk_d, tick_q, tick_d;
  logic [CHANNELS-1:0] wrap, apply, wr_sel;
  logic                ready_c, accept;

  // Out-of-range channels never match a pending slot, so they stay ready and are dropped.
  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pv_q[i] && (cfg_ch_i == CW'(i))) ready_c = 1'b0;
    end
    if (rst_i) ready_c = 1'b0;
  end

  assign cfg_ready_o = ready_c;
  assign accept      = cfg_valid_i & ready_c;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
      wrap[i]   = en_q[i] & sum[i][WIDTH];
      apply[i]  = pv_q[i] & (wrap[i] | ~en_q[i] | sync_in_i);
      wr_sel[i] = accept & (cfg_ch_i == CW'(i));

      acc_d[i] = acc_q[i];
      if (en_q[i])               acc_d[i] = sum[i][WIDTH-1:0];
      if (apply[i] && !en_q[i])  acc_d[i] = '0;
      if (sync_in_i)             acc_d[i] = '0;

      step_d[i]  = apply[i] ? pstep_q[i] : step_q[i];
      duty_d[i]  = apply[i] ? pduty_q[i] : duty_q[i];
      en_d[i]    = apply[i] ? pen_q[i]   : en_q[i];

      // A slot being applied is never writable this cycle, so fill and apply cannot collide.
      pv_d[i]    = wr_sel[i] ? 1'b1 : (apply[i] ? 1'b0 : pv_q[i]);
      pstep_d[i] = wr_sel[i] ? cfg_step_i : pstep_q[i];
      pduty_d[i] = wr_sel[i] ? cfg_duty_i : pduty_q[i];
      pen_d[i]   = wr_sel[i] ? cfg_en_i   : pen_q[i];

      clk_d[i]  = en_q[i] & (acc_q[i] >= duty_q[i]);
      tick_d[i] = clk_d[i] & ~clk_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]   <= '0;
        step_q[i]  <= '0;
        duty_q[i]  <= DUTY_RST;
        pstep_q[i] <= '0;
        pduty_q[i] <= '0;
      end
      en_q   <= '0;
      pen_q  <= '0;
      pv_q   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]   <= acc_d[i];
        step_q[i]  <= step_d[i];
        duty_q[i]  <= duty_d[i];
        pstep_q[i] <= pstep_d[i];
        pduty_q[i] <= pduty_d[i];
      end
      en_q   <= en_d;
      pen_q  <= pen_d;
      pv_q   <= pv_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_nco_clkgen.sv
// Self-checking bench for nco_clkgen: directed scenarios plus randomized traffic,
// compared every cycle against an arithmetic reference model.
module tb_nco_clkgen;
  localparam int N = 4;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, cfg_en, sync_in;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_step, cfg_duty;
  logic [3:0]  clk_out, tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nco_clkgen #(.WIDTH(32), .CHANNELS(N)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch), .cfg_step_i(cfg_step), .cfg_duty_i(cfg_duty), .cfg_en_i(cfg_en),
    .sync_in_i(sync_in), .clk_out_o(clk_out), .tick_o(tick)
  );

  longint unsigned m_acc[N], m_step[N], m_duty[N], m_pstep[N], m_pduty[N];
  bit              m_en[N], m_pv[N], m_pen[N];
  bit [3:0]        m_clk, m_tick;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    return !m_pv[cfg_ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 0; m_step[i] = 0; m_duty[i] = 64'h8000_0000;
      m_en[i] = 0; m_pv[i] = 0; m_pen[i] = 0; m_pstep[i] = 0; m_pduty[i] = 0;
    end
    m_clk = '0; m_tick = '0;
  endtask

  task automatic model_edge();
    bit took;
    took = cfg_valid && m_ready();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      longint unsigned s    = m_acc[i] + m_step[i];
      bit              wrp  = m_en[i] && (s >= MOD);
      bit              hi   = m_en[i] && (m_acc[i] >= m_duty[i]);
      bit              app  = m_pv[i] && (wrp || !m_en[i] || sync_in);
      longint unsigned nacc = m_en[i] ? (s % MOD) : m_acc[i];
      if (app && !m_en[i]) nacc = 0;
      if (sync_in) nacc = 0;
      m_tick[i] = hi && !m_clk[i];
      m_clk[i]  = hi;
      m_acc[i]  = nacc;
      if (app) begin
        m_step[i] = m_pstep[i]; m_duty[i] = m_pduty[i]; m_en[i] = m_pen[i]; m_pv[i] = 0;
      end
      if (took && int'(cfg_ch) == i) begin
        m_pv[i] = 1; m_pstep[i] = cfg_step; m_pduty[i] = cfg_duty; m_pen[i] = cfg_en;
      end
    end
  endtask

  task automatic cycle();
    #2;
    n_cmp++;
    assert (cfg_ready === m_ready()) else begin
      n_err++;
      $error("FAIL cfg_ready ch=%0d got=%b exp=%b", cfg_ch, cfg_ready, m_ready());
    end
    @(posedge clk);
    model_edge();
    #1;
    n_cmp++;
    assert (clk_out === m_clk) else begin
      n_err++;
      $error("FAIL clk_out got=%b exp=%b", clk_out, m_clk);
    end
    n_cmp++;
    assert (tick === m_tick) else begin
      n_err++;
      $error("FAIL tick got=%b exp=%b", tick, m_tick);
    end
  endtask

  task automatic write_cfg(input int ch, input logic [31:0] st, input logic [31:0] du, input bit en);
    bit done, a;
    done = 0;
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_step = st; cfg_duty = du; cfg_en = en;
    for (int k = 0; k < 64; k++) begin
      a = m_ready();
      cycle();
      if (a) begin
        done = 1;
        break;
      end
    end
    cfg_valid = 0;
    n_cmp++;
    assert (done === 1'b1) else begin
      n_err++;
      $error("FAIL write_timeout ch=%0d got=%b exp=1", ch, done);
    end
  endtask

  task automatic count_ticks(input int ch, input int n, input int exp_cnt);
    int c;
    c = 0;
    repeat (n) begin
      cycle();
      if (tick[ch] === 1'b1) c++;
    end
    n_cmp++;
    assert (c === exp_cnt) else begin
      n_err++;
      $error("FAIL tick_count ch=%0d got=%0d exp=%0d", ch, c, exp_cnt);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp_v);
    n_cmp++;
    assert (got === exp_v) else begin
      n_err++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp_v);
    end
  endtask

  initial begin
    rst = 1; cfg_valid = 1; cfg_ch = 0; cfg_step = 32'h1234_5678;
    cfg_duty = 0; cfg_en = 1; sync_in = 0;
    model_reset();

    // Reset holds off writes and outputs.
    repeat (3) cycle();
    check_bit("rst_clk_out0", clk_out[0], 1'b0);
    rst = 0; cfg_valid = 0;
    #1;
    check_bit("ready_after_rst", cfg_ready, 1'b1);

    // Basic run: period 4.
    write_cfg(0, 32'h4000_0000, 32'h8000_0000, 1);
    repeat (4) cycle();
    count_ticks(0, 16, 4);

    // Pending write stalls a second write; new period 8.
    write_cfg(0, 32'h2000_0000, 32'h8000_0000, 1);
    #1;
    check_bit("ready_pending", cfg_ready, 1'b0);
    write_cfg(0, 32'h2000_0000, 32'h8000_0000, 1);
    repeat (20) cycle();
    count_ticks(0, 16, 2);

    // Duty boundaries.
    write_cfg(0, 32'h0, 32'h0, 0);
    repeat (10) cycle();
    write_cfg(0, 32'h4000_0000, 32'h0, 1);
    count_ticks(0, 16, 1);
    check_bit("duty0_high", clk_out[0], 1'b1);
    write_cfg(0, 32'h4000_0000, 32'hFFFF_FFFF, 1);
    repeat (8) cycle();
    count_ticks(0, 16, 0);
    check_bit("dutymax_low", clk_out[0], 1'b0);

    // Sync alignment of two channels.
    write_cfg(0, 32'h4000_0000, 32'h8000_0000, 1);
    write_cfg(1, 32'h2000_0000, 32'h8000_0000, 1);
    repeat ($urandom_range(3, 12)) cycle();
    sync_in = 1;
    cycle();
    sync_in = 0;
    repeat (8) cycle();
    count_ticks(1, 16, 2);

    // Mid-operation reset with a pending write on ch2.
    write_cfg(2, 32'h4000_0000, 32'h8000_0000, 1);
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (m_clk[2]) break;
    end
    write_cfg(2, 32'h1000_0000, 32'h1000_0000, 1);
    rst = 1;
    cycle();
    rst = 0;
    check_bit("rst_mid_clk2", clk_out[2], 1'b0);
    check_bit("rst_mid_tick0", tick[0], 1'b0);
    cfg_ch = 2;
    #1;
    check_bit("rst_mid_ready2", cfg_ready, 1'b1);
    repeat (4) cycle();

    // Disable and re-enable ch3.
    write_cfg(3, 32'h4000_0000, 32'h8000_0000, 1);
    repeat (8) cycle();
    write_cfg(3, 32'h4000_0000, 32'h8000_0000, 0);
    repeat (6) cycle();
    check_bit("disabled_clk3", clk_out[3], 1'b0);
    count_ticks(3, 8, 0);
    write_cfg(3, 32'h4000_0000, 32'h8000_0000, 1);
    repeat (8) cycle();

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_step  = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 15) << 28);
      cfg_duty  = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 15) << 28);
      cfg_en    = ($urandom_range(0, 7) != 0);
      sync_in   = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0; cfg_valid = 0; sync_in = 0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
